// File: rtl/cpu_boot_sequencer_if.sv
// cpu_boot_sequencer_if: host word stream into the boot sequencer.
// Signals: in_valid/in_data from the source, in_ready back from the sink.
interface cpu_boot_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: loads imem from a word stream, holds the CPU in reset,
// then runs it until the PC limit or a cycle timeout is reached.
// Ports: clk/rst (sync, active-high); load_start/load_len start a sequence;
// src (slave) carries in_valid/in_data/in_ready; imem_we/imem_addr/imem_wdata
// write the instruction memory; cpu_rst drives the CPU reset; cpu_pc is the
// CPU byte PC; busy/done/timeout/cycle_count report progress and result.
module cpu_boot_sequencer #(
   parameter int          DATA_WIDTH     = 32,
   parameter int          IMEM_DEPTH     = 1024,
   parameter int          ADDR_WIDTH     = 10,
   parameter logic [31:0] MAX_INSTR_ADDR = 32'h48,
   parameter int          RESET_HOLD     = 2,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH:0]   load_len,
   cpu_boot_sequencer_if.slave   src,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_rst,
   input  logic [31:0]           cpu_pc,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [31:0]           cycle_count
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [CW-1:0] DEPTH = CW'(IMEM_DEPTH);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HOLD,
      RUN,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] wcnt;
   logic [CW-1:0] len;
   logic [CW-1:0] len_eff;
   logic [CW-1:0] wnext;
   logic [HW-1:0] hold_cnt;
   logic          first;
   logic          pc_hit;
   logic          to_hit;

   // Oversized requests are clamped so the word index never wraps.
   assign len_eff = (load_len > DEPTH) ? DEPTH : load_len;
   assign wnext   = wcnt + CW'(1);

   assign src.in_ready = (state == LOAD);

   // First RUN cycle ignores the PC: it may still be stale from reset.
   assign pc_hit = !first && (cpu_pc >= MAX_INSTR_ADDR);
   assign to_hit = (cycle_count + 32'd1) == TIMEOUT_CYCLES;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cpu_rst     <= 1'b1;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         wcnt        <= '0;
         len         <= '0;
         hold_cnt    <= '0;
         first       <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (load_start) begin
                  done        <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
                  wcnt        <= '0;
                  hold_cnt    <= '0;
                  len         <= len_eff;
                  busy        <= 1'b1;
                  state       <= (len_eff == '0) ? HOLD : LOAD;
               end
            end
            LOAD: begin
               if (src.in_valid) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= wcnt[ADDR_WIDTH-1:0];
                  imem_wdata <= src.in_data;
                  wcnt       <= wnext;
                  if (wnext == len) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state   <= RUN;
                  cpu_rst <= 1'b0;
                  first   <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            RUN: begin
               first <= 1'b0;
               if (cycle_count != '1) begin
                  cycle_count <= cycle_count + 32'd1;
               end
               if (pc_hit || to_hit) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  timeout <= !pc_hit;
                  busy    <= 1'b0;
                  cpu_rst <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               cpu_rst <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/cpu_boot_sequencer.md
Name: cpu_boot_sequencer

Overview:
- Parametrised boot and run controller for the pipelined CPU.
- Replaces bench-side file preloading and hand-toggled reset with a synthesizable sequence:
  - stream a program image into instruction memory over a valid/ready port;
  - hold the CPU in reset for a programmable interval, then release it;
  - count run cycles and stop on end-of-program (PC limit) or timeout.
- Sits between a host/bench word source, the CPU's instruction-memory write port and the CPU reset input.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- IMEM_DEPTH, 1024, instruction memory depth in words.
- ADDR_WIDTH, 10, word-address width; must satisfy 2^ADDR_WIDTH >= IMEM_DEPTH.
- MAX_INSTR_ADDR, 32'h48, byte address; the CPU reaching this PC or beyond ends the run.
- RESET_HOLD, 2, CPU reset hold cycles after load completes; minimum 1.
- TIMEOUT_CYCLES, 65535, run-cycle limit before forced stop.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle request to begin a load/run sequence.
- load_len  in  ADDR_WIDTH+1  number of words to load; sampled with load_start.
- in_valid  in  1  source word valid.
- in_data  in  DATA_WIDTH  source word.
- in_ready  out  1  sequencer accepts a word this cycle.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wdata  out  DATA_WIDTH  write data.
- cpu_rst  out  1  reset to the CPU; active-high.
- cpu_pc  in  32  current CPU PC, byte address.
- busy  out  1  high in LOAD, HOLD and RUN.
- done  out  1  run finished; held until the next load_start or rst.
- timeout  out  1  run ended by TIMEOUT_CYCLES; valid while done=1.
- cycle_count  out  32  number of RUN cycles elapsed.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE;
  - cpu_rst=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0;
  - busy=0; done=0; timeout=0; cycle_count=0.
  - Applies mid-operation too: a load in progress is aborted, and words already written stay in memory (no clearing).
- States: IDLE, LOAD, HOLD, RUN, DONE. cpu_rst=1 in every state except RUN.
- IDLE or DONE, load_start=1:
  - clears done, timeout and cycle_count; resets the word counter.
  - load_len=0 -> go to HOLD; the existing memory image is run unchanged.
  - load_len > IMEM_DEPTH -> clamp to IMEM_DEPTH.
  - otherwise -> go to LOAD.
  - load_start is ignored in LOAD, HOLD and RUN.
- LOAD:
  - in_ready=1, combinational from state only.
  - A transfer occurs when in_valid && in_ready; in_valid is ignored in all other states.
  - Write latency is one cycle: the cycle after a transfer, imem_we=1, imem_addr=word index (0,1,2,...), imem_wdata=the transferred word. imem_we=0 otherwise.
  - When the final word transfers, the state moves to HOLD at the same edge; that word's write completes in the first HOLD cycle.
- HOLD:
  - cpu_rst=1 for exactly RESET_HOLD cycles, counted from HOLD entry; then go to RUN.
- RUN:
  - cpu_rst=0.
  - cycle_count increments every RUN cycle, saturating at 32'hFFFFFFFF.
  - Stop checks are evaluated each RUN cycle on registered values:
    - cpu_pc >= MAX_INSTR_ADDR (unsigned) -> DONE, done=1, timeout=0.
    - else cycle_count+1 == TIMEOUT_CYCLES -> DONE, done=1, timeout=1.
    - If both hold in the same cycle, the PC condition wins (timeout=0).
  - The PC check is suppressed in the first RUN cycle, so a stale PC from before reset cannot end the run.
- DONE:
  - cpu_rst=1 (CPU frozen); cycle_count frozen; done and timeout held.
- Address wrap cannot occur because of the load_len clamp. The word counter is ADDR_WIDTH+1 bits wide, so load_len=IMEM_DEPTH works.

Test Plan:
- Basic load: rst 1 cycle, load_start with load_len=4, in_valid held high with words A0..A3 -> imem_we pulses at addresses 0..3 one cycle after each transfer; cpu_rst stays 1 for 2 HOLD cycles, then falls.
- Backpressure/gaps: in_valid toggled 1,0,0,1,... over 18 words -> exactly 18 writes at addresses 0..17 in order, no duplicates; in_ready=0 outside LOAD.
- End of program: cpu_pc model advances 4 per cycle from 0 -> done=1 and cpu_rst=1 on the cycle after PC reaches 32'h48; cycle_count=19; timeout=0.
- Timeout: TIMEOUT_CYCLES=10, cpu_pc held at 0 -> done=1, timeout=1, cycle_count=10, and cycle_count holds at 10 afterwards.
- Edge lengths and simultaneous stop: load_len=0 -> no writes, RUN after RESET_HOLD cycles; load_len=2000 -> clamped to 1024 writes; PC limit and timeout hit in the same cycle -> timeout=0.
- Reset mid-load: rst asserted after 3 of 8 words -> IDLE next cycle, in_ready=0, busy=0; a following load_start restarts writes at address 0.
